// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e      : arbiter FSM state encoding (IDLE / SEND / HOLD)
//   HOLD_MAX_DEFAULT : default idle budget for a frame-locked owner
package uart_arb_pkg;

    localparam int HOLD_MAX_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at ptr+1 (modulo NUM_REQ), so the last winner has the
// lowest priority.
//   valid     in  : request vector
//   ptr       in  : index of the previous winner
//   grant     out : one-hot winner (all zero if nothing is valid)
//   grant_idx out : binary index of the winner
//   any_valid out : at least one request is valid
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = |valid;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into one UART
// transmitter. One byte is held in a register toward the transmitter; a new
// byte is only taken after the previous one has been handed over, leaving at
// least one idle cycle between bytes.
//
// Build option: define UART_ARB_FRAME_LOCK_EN to keep the grant on a
// requester until it presents a byte with req_last set (or idles for
// HOLD_MAX cycles). Without it req_last is ignored and every byte is
// arbitrated on its own.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/data/last   per-requester byte offer
//   req_ready             one-hot, combinational: byte taken this cycle
//   tx_data/tx_data_valid registered byte toward the transmitter
//   tx_data_ready         transmitter takes the byte
//   grant_id              current / most recent owner
//   busy                  FSM not in IDLE
//   hold_timeout          one-cycle pulse when a locked owner is released
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; pick a requester round-robin and take its byte
// SEND    | byte presented to transmitter, waiting for tx_data_ready
// HOLD    | frame lock: wait for the owner's next byte or idle timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_data_valid,
    input  logic                       tx_data_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       hold_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic [IDX_W-1:0] accept_idx;
    logic [7:0]       accept_byte;
    logic             tx_done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    assign tx_done     = tx_data_valid && tx_data_ready;
    assign busy        = (state != ST_IDLE);
    assign accept_byte = req_data[int'(accept_idx)*8 +: 8];

    // req_ready is combinational so it can never fire for a non-valid
    // requester; it is suppressed during reset so nothing is lost then.
    always_comb begin
        req_ready  = '0;
        accept     = 1'b0;
        accept_idx = grant_id;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        req_ready  = pick_onehot;
                        accept     = 1'b1;
                        accept_idx = pick_idx;
                    end
                end
`ifdef UART_ARB_FRAME_LOCK_EN
                ST_HOLD: begin
                    if (req_valid[grant_id]) begin
                        req_ready[grant_id] = 1'b1;
                        accept              = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef UART_ARB_FRAME_LOCK_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic             last_q;
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    assign hold_timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            last_q        <= 1'b0;
            hold_cnt      <= '0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data       <= accept_byte;
                        tx_data_valid <= 1'b1;
                        grant_id      <= accept_idx;
                        last_q        <= req_last[accept_idx];
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        tx_data_valid <= 1'b0;
                        if (last_q) begin
                            rr_ptr <= grant_id;
                            state  <= ST_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        tx_data       <= accept_byte;
                        tx_data_valid <= 1'b1;
                        last_q        <= req_last[grant_id];
                        hold_cnt      <= '0;
                        state         <= ST_SEND;
                    end else if (hold_cnt >= CNT_W'(HOLD_MAX - 1)) begin
                        // This idle cycle brings the count to HOLD_MAX.
                        hold_cnt  <= CNT_W'(HOLD_MAX);
                        timeout_q <= 1'b1;
                        rr_ptr    <= grant_id;
                        state     <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_last;

    assign unused_last  = ^req_last;
    assign hold_timeout = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data       <= accept_byte;
                        tx_data_valid <= 1'b1;
                        grant_id      <= accept_idx;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        tx_data_valid <= 1'b0;
                        rr_ptr        <= grant_id;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, HOLD_MAX=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        hold_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .HOLD_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .hold_timeout  (hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  exp_rr;
        logic        exp_txv;
        logic [7:0]  exp_txd;
        logic [1:0]  exp_gid;
        logic        exp_busy;
        logic        exp_to;
    } vec_t;

    vec_t tbl_main[$];
    vec_t tbl_mode[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic r,
                                logic [3:0] err, logic ev, logic [7:0] ed,
                                logic [1:0] eg, logic eb, logic et);
        vec_t t;
        t.valid = v;    t.last = l;     t.data = d;     t.ready = r;
        t.exp_rr = err; t.exp_txv = ev; t.exp_txd = ed; t.exp_gid = eg;
        t.exp_busy = eb; t.exp_to = et;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic rdy);
        @(posedge clk);
        #1;
        rst           = r;
        req_valid     = v;
        req_last      = l;
        req_data      = d;
        tx_data_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready",     req_ready,     0);
        chk("rst.tx_data_valid", tx_data_valid, 0);
        chk("rst.tx_data",       tx_data,       0);
        chk("rst.grant_id",      grant_id,      0);
        chk("rst.busy",          busy,          0);
        chk("rst.hold_timeout",  hold_timeout,  0);
    endtask

    task automatic run_table(input string tag, input vec_t tbl[$]);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].ready);
            chk($sformatf("%s[%0d].req_ready", tag, i), req_ready, tbl[i].exp_rr);
            chk($sformatf("%s[%0d].tx_valid", tag, i), tx_data_valid, tbl[i].exp_txv);
            if (tbl[i].exp_txv)
                chk($sformatf("%s[%0d].tx_data", tag, i), tx_data, tbl[i].exp_txd);
            chk($sformatf("%s[%0d].grant_id", tag, i), grant_id, tbl[i].exp_gid);
            chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].exp_busy);
            chk($sformatf("%s[%0d].hold_to", tag, i), hold_timeout, tbl[i].exp_to);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b0;

        // Requesters 0 and 2 first, then round-robin rotation with a stall.
        //                  valid    last     data          rdy  rr       txv   txd    gid   busy  to
        tbl_main.push_back(mk(4'b0101, 4'b1111, 32'hD3C2B1A0, 1, 4'b0001, 0, 8'h00, 2'd0, 0, 0));
        tbl_main.push_back(mk(4'b0100, 4'b1111, 32'hD3C2B1A0, 1, 4'b0000, 1, 8'hA0, 2'd0, 1, 0));
        tbl_main.push_back(mk(4'b0100, 4'b1111, 32'hD3C2B1A0, 1, 4'b0100, 0, 8'h00, 2'd0, 0, 0));
        tbl_main.push_back(mk(4'b0000, 4'b1111, 32'hD3C2B1A0, 1, 4'b0000, 1, 8'hC2, 2'd2, 1, 0));
        tbl_main.push_back(mk(4'b0000, 4'b1111, 32'hD3C2B1A0, 1, 4'b0000, 0, 8'h00, 2'd2, 0, 0));
        tbl_main.push_back(mk(4'b1111, 4'b1111, 32'hD3C2B1A0, 1, 4'b1000, 0, 8'h00, 2'd2, 0, 0));
        tbl_main.push_back(mk(4'b1111, 4'b1111, 32'hD3C2B1A0, 0, 4'b0000, 1, 8'hD3, 2'd3, 1, 0));
        tbl_main.push_back(mk(4'b1111, 4'b1111, 32'hD3C2B1A0, 1, 4'b0000, 1, 8'hD3, 2'd3, 1, 0));
        tbl_main.push_back(mk(4'b1111, 4'b1111, 32'hD3C2B1A0, 1, 4'b0001, 0, 8'h00, 2'd3, 0, 0));
        tbl_main.push_back(mk(4'b0000, 4'b1111, 32'hD3C2B1A0, 1, 4'b0000, 1, 8'hA0, 2'd0, 1, 0));
        tbl_main.push_back(mk(4'b0000, 4'b1111, 32'hD3C2B1A0, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 0));

`ifdef UART_ARB_FRAME_LOCK_EN
        // Requester 1 frame 0x41,0x42(last); requester 3 (0x33) waits it out.
        tbl_mode.push_back(mk(4'b1010, 4'b1000, 32'h33004100, 1, 4'b0010, 0, 8'h00, 2'd0, 0, 0));
        tbl_mode.push_back(mk(4'b1010, 4'b1010, 32'h33004200, 1, 4'b0000, 1, 8'h41, 2'd1, 1, 0));
        tbl_mode.push_back(mk(4'b1010, 4'b1010, 32'h33004200, 1, 4'b0010, 0, 8'h00, 2'd1, 1, 0));
        tbl_mode.push_back(mk(4'b1000, 4'b1010, 32'h33004200, 1, 4'b0000, 1, 8'h42, 2'd1, 1, 0));
        tbl_mode.push_back(mk(4'b1000, 4'b1010, 32'h33004200, 1, 4'b1000, 0, 8'h00, 2'd1, 0, 0));
        tbl_mode.push_back(mk(4'b0000, 4'b1010, 32'h33004200, 1, 4'b0000, 1, 8'h33, 2'd3, 1, 0));
        tbl_mode.push_back(mk(4'b0000, 4'b1010, 32'h33004200, 1, 4'b0000, 0, 8'h00, 2'd3, 0, 0));
`else
        // Requester 0 frame 0x10(last=0),0x11; requester 1 (0x21) slips in between.
        tbl_mode.push_back(mk(4'b0011, 4'b0000, 32'h00002110, 1, 4'b0001, 0, 8'h00, 2'd0, 0, 0));
        tbl_mode.push_back(mk(4'b0011, 4'b0000, 32'h00002111, 1, 4'b0000, 1, 8'h10, 2'd0, 1, 0));
        tbl_mode.push_back(mk(4'b0011, 4'b0000, 32'h00002111, 1, 4'b0010, 0, 8'h00, 2'd0, 0, 0));
        tbl_mode.push_back(mk(4'b0001, 4'b0000, 32'h00002111, 1, 4'b0000, 1, 8'h21, 2'd1, 1, 0));
        tbl_mode.push_back(mk(4'b0001, 4'b0000, 32'h00002111, 1, 4'b0001, 0, 8'h00, 2'd1, 0, 0));
        tbl_mode.push_back(mk(4'b0000, 4'b0000, 32'h00002111, 1, 4'b0000, 1, 8'h11, 2'd0, 1, 0));
        tbl_mode.push_back(mk(4'b0000, 4'b0000, 32'h00002111, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 0));
`endif

        do_reset();
        run_table("main", tbl_main);

        do_reset();
        run_table("mode", tbl_mode);

`ifdef UART_ARB_FRAME_LOCK_EN
        // Locked owner 1 goes quiet: release after HOLD_MAX idle cycles.
        do_reset();
        drive(1'b0, 4'b0010, 4'b0100, 32'h00C25500, 1'b1);
        chk("hold.accept", req_ready, 4'b0010);
        drive(1'b0, 4'b0101, 4'b0100, 32'h00C255A0, 1'b1);
        chk("hold.tx_data", tx_data, 8'h55);
        chk("hold.tx_valid", tx_data_valid, 1);
        for (int h = 1; h <= 4; h++) begin
            drive(1'b0, 4'b0101, 4'b0100, 32'h00C255A0, 1'b1);
            chk($sformatf("hold.c%0d.req_ready", h), req_ready, 0);
            chk($sformatf("hold.c%0d.busy", h), busy, 1);
            chk($sformatf("hold.c%0d.timeout", h), hold_timeout, 0);
            chk($sformatf("hold.c%0d.tx_valid", h), tx_data_valid, 0);
        end
        drive(1'b0, 4'b0101, 4'b0100, 32'h00C255A0, 1'b1);
        chk("hold.timeout_pulse", hold_timeout, 1);
        chk("hold.busy_after", busy, 0);
        chk("hold.next_pick", req_ready, 4'b0100);
        drive(1'b0, 4'b0000, 4'b0100, 32'h00C255A0, 1'b1);
        chk("hold.timeout_end", hold_timeout, 0);
        chk("hold.next_data", tx_data, 8'hC2);
        chk("hold.next_gid", grant_id, 2);
`endif

        // Transmitter stalls for 10 cycles while everyone requests.
        do_reset();
        drive(1'b0, 4'b0010, 4'b1111, 32'hD3C2B1A0, 1'b0);
        chk("stall.accept", req_ready, 4'b0010);
        for (int s = 0; s < 10; s++) begin
            drive(1'b0, 4'b1111, 4'b1111, 32'hD3C2EEA0, 1'b0);
            chk($sformatf("stall.%0d.tx_valid", s), tx_data_valid, 1);
            chk($sformatf("stall.%0d.tx_data", s), tx_data, 8'hB1);
            chk($sformatf("stall.%0d.req_ready", s), req_ready, 0);
            chk($sformatf("stall.%0d.grant_id", s), grant_id, 1);
        end
        drive(1'b0, 4'b0000, 4'b1111, 32'hD3C2EEA0, 1'b1);
        chk("stall.release_valid", tx_data_valid, 1);
        drive(1'b0, 4'b0000, 4'b1111, 32'hD3C2EEA0, 1'b1);
        chk("stall.done_valid", tx_data_valid, 0);
        chk("stall.done_busy", busy, 0);

        // Reset while a byte is waiting in SEND.
        do_reset();
        drive(1'b0, 4'b0010, 4'b1111, 32'hD3C2B1A0, 1'b0);
        chk("rsend.accept", req_ready, 4'b0010);
        drive(1'b0, 4'b0000, 4'b1111, 32'hD3C2B1A0, 1'b0);
        chk("rsend.in_send", busy, 1);
        drive(1'b1, 4'b0000, 4'b1111, 32'hD3C2B1A0, 1'b0);
        drive(1'b1, 4'b0101, 4'b1111, 32'hD3C2B1A0, 1'b0);
        chk("rsend.tx_valid", tx_data_valid, 0);
        chk("rsend.busy", busy, 0);
        chk("rsend.grant_id", grant_id, 0);
        chk("rsend.req_ready_in_rst", req_ready, 0);
        drive(1'b0, 4'b0101, 4'b1111, 32'hD3C2B1A0, 1'b1);
        chk("rsend.first_pick", req_ready, 4'b0001);
        drive(1'b0, 4'b0000, 4'b1111, 32'hD3C2B1A0, 1'b1);
        chk("rsend.tx_data", tx_data, 8'hA0);
        chk("rsend.gid", grant_id, 0);
        drive(1'b0, 4'b0000, 4'b1111, 32'hD3C2B1A0, 1'b1);
        chk("rsend.idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
